// File: rtl/l80_spi_port_if.sv
// CPU-side I/O bus bundle for the l80_spi_port peripheral.
// The CPU (or bench) drives it through the master modport; the peripheral uses the slave modport.
interface l80_spi_port_if;
    logic [7:0] io_addr;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_din;
    logic [7:0] io_dout;

    modport master (
        output io_addr,
        output io_wr,
        output io_rd,
        output io_din,
        input  io_dout
    );

    modport slave (
        input  io_addr,
        input  io_wr,
        input  io_rd,
        input  io_din,
        output io_dout
    );
endinterface

// File: rtl/l80_spi_port.sv
// Light8080 SOC SPI master: DATA/STAT/CTRL/DIV registers at BASE_ADDR..+3, one byte per DATA write.
// Define SPI_MODE_SEL_EN to add CPOL/CPHA selection in CTRL[3:2]; otherwise only mode 0 exists.
module l80_spi_port #(
    parameter logic [7:0] BASE_ADDR = 8'h90,
    parameter logic [7:0] DIV_RST   = 8'h03
) (
    input  logic            clk,
    input  logic            rstb,
    l80_spi_port_if.slave   bus,
    output logic            sck,
    output logic            mosi,
    input  logic            miso,
    output logic            ss_n,
    output logic            busy,
    output logic            irq
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state_q, state_d;
    logic [7:0] shreg_q;
    logic [7:0] rx_data_q;
    logic [7:0] div_q;
    logic [7:0] cnt_q;
    logic [3:0] edge_cnt_q;
    logic       sck_q;
    logic       mosi_q;
    logic       ss_n_q;
    logic       done_q;
    logic       ovr_q;
    logic       ctrl_lsb_q;
    logic       xfer_lsb_q;

    logic       cfg_cpol;
    logic       cfg_cpha;
    logic       xfer_cpha;

    // Address decode works for any base, including ones not aligned to 4.
    logic [7:0] offset;
    logic       hit;
    logic       wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
    logic       start, ovr_set;
    logic       half_tick, last_edge, sample_edge, drive_edge;
    logic [7:0] shift_val;

    assign offset  = bus.io_addr - BASE_ADDR;
    assign hit     = (offset[7:2] == 6'd0);
    assign wr_data = bus.io_wr & hit & (offset[1:0] == 2'd0);
    assign wr_stat = bus.io_wr & hit & (offset[1:0] == 2'd1);
    assign wr_ctrl = bus.io_wr & hit & (offset[1:0] == 2'd2);
    assign wr_div  = bus.io_wr & hit & (offset[1:0] == 2'd3);
    assign rd_data = bus.io_rd & hit & (offset[1:0] == 2'd0);

    assign start   = wr_data & (state_q == IDLE);
    assign ovr_set = wr_data & (state_q == XFER);

    // edge_cnt_q counts completed edges, so edge number edge_cnt_q+1 is odd when bit 0 is clear.
    assign half_tick   = (state_q == XFER) && (cnt_q == 8'd0);
    assign last_edge   = half_tick && (edge_cnt_q == 4'd15);
    assign sample_edge = half_tick && (edge_cnt_q[0] == xfer_cpha);
    assign drive_edge  = half_tick && (edge_cnt_q[0] != xfer_cpha) && !last_edge;

    assign shift_val = xfer_lsb_q ? {miso, shreg_q[7:1]} : {shreg_q[6:0], miso};

`ifdef SPI_MODE_SEL_EN
    logic ctrl_cpol_q;
    logic ctrl_cpha_q;
    logic xfer_cpha_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ctrl_cpol_q <= 1'b0;
            ctrl_cpha_q <= 1'b0;
            xfer_cpha_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_cpol_q <= bus.io_din[3];
                ctrl_cpha_q <= bus.io_din[2];
            end
            if (start) begin
                xfer_cpha_q <= ctrl_cpha_q;
            end
        end
    end

    assign cfg_cpol  = ctrl_cpol_q;
    assign cfg_cpha  = ctrl_cpha_q;
    assign xfer_cpha = xfer_cpha_q;
`else
    assign cfg_cpol  = 1'b0;
    assign cfg_cpha  = 1'b0;
    assign xfer_cpha = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = XFER;
            XFER:    if (last_edge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and the CPU read mux
    always_comb begin
        busy        = (state_q == XFER);
        irq         = done_q;
        sck         = sck_q;
        mosi        = mosi_q;
        ss_n        = ss_n_q;
        bus.io_dout = 8'h00;
        if (hit) begin
            case (offset[1:0])
                2'd0:    bus.io_dout = rx_data_q;
                2'd1:    bus.io_dout = {5'b0, ovr_q, done_q, (state_q == XFER)};
                2'd2:    bus.io_dout = {4'b0, cfg_cpol, cfg_cpha, ctrl_lsb_q, ~ss_n_q};
                default: bus.io_dout = div_q;
            endcase
        end
    end

    // Shift engine: sck, mosi, shift register and half-period timing
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shreg_q    <= 8'h00;
            cnt_q      <= 8'h00;
            edge_cnt_q <= 4'd0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            xfer_lsb_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sck_q <= cfg_cpol;
            if (start) begin
                shreg_q    <= bus.io_din;
                xfer_lsb_q <= ctrl_lsb_q;
                cnt_q      <= div_q;
                edge_cnt_q <= 4'd0;
                // With CPHA=1 the first bit goes out on the first sck edge instead.
                if (!cfg_cpha) begin
                    mosi_q <= ctrl_lsb_q ? bus.io_din[0] : bus.io_din[7];
                end
            end
        end else begin
            if (cnt_q == 8'd0) begin
                cnt_q      <= div_q;
                sck_q      <= ~sck_q;
                edge_cnt_q <= edge_cnt_q + 4'd1;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (sample_edge) begin
                shreg_q <= shift_val;
            end
            if (drive_edge) begin
                mosi_q <= xfer_lsb_q ? shreg_q[0] : shreg_q[7];
            end
        end
    end

    // CPU-visible registers and status flags
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_data_q  <= 8'h00;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ss_n_q     <= 1'b1;
            ctrl_lsb_q <= 1'b0;
            div_q      <= DIV_RST;
        end else begin
            if (last_edge) begin
                rx_data_q <= sample_edge ? shift_val : shreg_q;
            end
            // Setting a flag beats clearing it in the same cycle.
            if (last_edge) begin
                done_q <= 1'b1;
            end else if (rd_data) begin
                done_q <= 1'b0;
            end
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (wr_stat) begin
                ovr_q <= 1'b0;
            end
            if (wr_ctrl) begin
                ss_n_q     <= ~bus.io_din[0];
                ctrl_lsb_q <= bus.io_din[1];
            end
            if (wr_div) begin
                div_q <= bus.io_din;
            end
        end
    end

endmodule
